// File: rtl/pll_lock_pkg.sv
// Shared types and defaults for the PLL lock manager: state encoding,
// default timing constants and counter/retry width helpers.
package pll_lock_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // 74.25 MHz reference: 742500 cycles is a 10 ms lock window.
    localparam int DEF_RESET_CYCLES  = 16;
    localparam int DEF_LOCK_TIMEOUT  = 742500;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold a count from 0 to max_cycles-1 (at least 1).
    function automatic int cnt_width(input int max_cycles);
        return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
    endfunction

    // Bits needed to hold 0..max_retries (at least 1).
    function automatic int rc_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    localparam int DEF_CNT_W =
        cnt_width(max3(DEF_RESET_CYCLES, DEF_LOCK_TIMEOUT, DEF_STABLE_CYCLES));

endpackage

// File: rtl/pll_lock_manager_if.sv
// PLL-side and core-side status/control bundle of the lock manager.
// master = the lock manager, slave = whoever owns the PLL/core wiring.
interface pll_lock_manager_if import pll_lock_pkg::*; #(
    parameter int MAX_RETRIES = DEF_MAX_RETRIES
);
    localparam int RC_W = rc_width(MAX_RETRIES);

    logic            pll_locked;
    logic            relock_req;
    logic            pll_rst;
    logic            sys_reset;
    logic            pll_ready;
    logic            pll_failed;
    logic [RC_W-1:0] retry_count;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_reset, pll_ready, pll_failed, retry_count
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_reset, pll_ready, pll_failed, retry_count
    );

endinterface

// File: rtl/pll_lock_manager_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs;
// both stages clear to 0 on synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= '0;
        else       ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/pll_lock_manager.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the core; retries on timeout and parks in FAIL when exhausted.
module pll_lock_manager import pll_lock_pkg::*; #(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    pll_lock_manager_if.master bus
);
    localparam int RC_W = rc_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRIES);

    logic             locked_s;
    pll_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RC_W-1:0]  retry, retry_nxt;
    logic             pll_rst_q, sys_reset_q, pll_ready_q, pll_failed_q;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    // Every transition clears cnt; relock_req overrides anything the state wants.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        if (bus.relock_req) begin
            state_nxt = ST_PLL_RESET;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            unique case (state)
                ST_PLL_RESET: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_STABILIZE;
                        cnt_nxt   = '0;
                    end else if (cnt == TO_LAST) begin
                        cnt_nxt = '0;
                        if (retry == RETRY_MAX) begin
                            state_nxt = ST_FAIL;
                        end else begin
                            state_nxt = ST_PLL_RESET;
                            retry_nxt = retry + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_STABILIZE: begin
                    // A lock drop here is a glitch, not a timeout: no retry consumed.
                    if (!locked_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STAB_LAST) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_nxt = ST_PLL_RESET;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_PLL_RESET;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they flip in the same cycle as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_PLL_RESET;
            cnt          <= '0;
            retry        <= '0;
            pll_rst_q    <= 1'b1;
            sys_reset_q  <= 1'b1;
            pll_ready_q  <= 1'b0;
            pll_failed_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            retry        <= retry_nxt;
            pll_rst_q    <= (state_nxt == ST_PLL_RESET);
            sys_reset_q  <= (state_nxt != ST_RUN);
            pll_ready_q  <= (state_nxt == ST_RUN);
            pll_failed_q <= (state_nxt == ST_FAIL);
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_reset   = sys_reset_q;
    assign bus.pll_ready   = pll_ready_q;
    assign bus.pll_failed  = pll_failed_q;
    assign bus.retry_count = retry;

endmodule

// File: tb/tb_pll_lock_manager.sv
// Directed bench for pll_lock_manager with short timing parameters;
// cycle 0 is the first cycle after reset is dropped.
module tb_pll_lock_manager;

    localparam int RC = 4;
    localparam int TO = 100;
    localparam int SC = 8;
    localparam int MR = 2;
    localparam int CW = 7;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pll_lock_manager_if #(.MAX_RETRIES(MR)) bus ();

    pll_lock_manager #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance to cycle n and settle 1 time unit past the edge.
    task automatic to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic release_reset(input logic lk);
        bus.relock_req = 1'b0;
        bus.pll_locked = lk;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        bus.relock_req = 1'b0;
        bus.pll_locked = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL reset_pll_rst got %b exp 1", bus.pll_rst); end
        n_cmp++; if (bus.sys_reset !== 1'b1) begin n_bad++; $display("FAIL reset_sys_reset got %b exp 1", bus.sys_reset); end
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pll_ready got %b exp 0", bus.pll_ready); end
        n_cmp++; if (bus.pll_failed !== 1'b0) begin n_bad++; $display("FAIL reset_pll_failed got %b exp 0", bus.pll_failed); end
        n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL reset_retry got %0d exp 0", bus.retry_count); end
    endtask

    task automatic test_power_on;
        logic e;
        release_reset(1'b1);
        for (int c = 0; c < 15; c++) begin
            to(c);
            e = (c < RC);
            n_cmp++; if (bus.pll_rst !== e) begin n_bad++; $display("FAIL pon_pll_rst cyc=%0d got %b exp %b", c, bus.pll_rst, e); end
            e = (c < RC + 1 + SC);
            n_cmp++; if (bus.sys_reset !== e) begin n_bad++; $display("FAIL pon_sys_reset cyc=%0d got %b exp %b", c, bus.sys_reset, e); end
            n_cmp++; if (bus.pll_ready !== !e) begin n_bad++; $display("FAIL pon_pll_ready cyc=%0d got %b exp %b", c, bus.pll_ready, !e); end
        end
        n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL pon_retry got %0d exp 0", bus.retry_count); end
    endtask

    task automatic test_lock_timeout;
        int hi;
        hi = 0;
        release_reset(1'b0);
        for (int c = 0; c < 400; c++) begin
            to(c);
            if (bus.pll_rst === 1'b1) hi++;
            if (c == 103) begin
                n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL to_retry103 got %0d exp 0", bus.retry_count); end
                n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL to_rst103 got %b exp 0", bus.pll_rst); end
            end
            if (c == 104) begin
                n_cmp++; if (bus.retry_count !== 2'd1) begin n_bad++; $display("FAIL to_retry104 got %0d exp 1", bus.retry_count); end
                n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL to_rst104 got %b exp 1", bus.pll_rst); end
            end
            if (c == 208) begin
                n_cmp++; if (bus.retry_count !== 2'd2) begin n_bad++; $display("FAIL to_retry208 got %0d exp 2", bus.retry_count); end
            end
            if (c == 311) begin
                n_cmp++; if (bus.pll_failed !== 1'b0) begin n_bad++; $display("FAIL to_failed311 got %b exp 0", bus.pll_failed); end
            end
            if (c == 312) begin
                n_cmp++; if (bus.pll_failed !== 1'b1) begin n_bad++; $display("FAIL to_failed312 got %b exp 1", bus.pll_failed); end
                n_cmp++; if (bus.sys_reset !== 1'b1) begin n_bad++; $display("FAIL to_sysrst312 got %b exp 1", bus.sys_reset); end
                n_cmp++; if (bus.retry_count !== 2'd2) begin n_bad++; $display("FAIL to_retry312 got %0d exp 2", bus.retry_count); end
            end
        end
        n_cmp++; if (hi != 3 * RC) begin n_bad++; $display("FAIL to_rst_cycles got %0d exp %0d", hi, 3 * RC); end
        n_cmp++; if (bus.pll_failed !== 1'b1) begin n_bad++; $display("FAIL to_failed399 got %b exp 1", bus.pll_failed); end
    endtask

    // Continues from FAIL left by test_lock_timeout.
    task automatic test_relock_from_fail;
        to(400);
        bus.pll_locked = 1'b1;
        to(410);
        bus.relock_req = 1'b1;
        to(411);
        bus.relock_req = 1'b0;
        n_cmp++; if (bus.pll_failed !== 1'b0) begin n_bad++; $display("FAIL rf_failed got %b exp 0", bus.pll_failed); end
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL rf_pll_rst got %b exp 1", bus.pll_rst); end
        n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL rf_retry got %0d exp 0", bus.retry_count); end
        to(423);
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL rf_ready423 got %b exp 0", bus.pll_ready); end
        to(424);
        n_cmp++; if (bus.pll_ready !== 1'b1) begin n_bad++; $display("FAIL rf_ready424 got %b exp 1", bus.pll_ready); end
        n_cmp++; if (bus.sys_reset !== 1'b0) begin n_bad++; $display("FAIL rf_sysrst424 got %b exp 0", bus.sys_reset); end
    endtask

    task automatic test_lock_bounce;
        release_reset(1'b0);
        to(50); bus.pll_locked = 1'b1;
        to(55); bus.pll_locked = 1'b0;
        to(61);
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL lb_ready61 got %b exp 0", bus.pll_ready); end
        to(65); bus.pll_locked = 1'b1;
        to(75);
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL lb_ready75 got %b exp 0", bus.pll_ready); end
        to(76);
        n_cmp++; if (bus.pll_ready !== 1'b1) begin n_bad++; $display("FAIL lb_ready76 got %b exp 1", bus.pll_ready); end
        n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL lb_retry got %0d exp 0", bus.retry_count); end
        n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL lb_pll_rst got %b exp 0", bus.pll_rst); end
    endtask

    // Continues in RUN from test_lock_bounce.
    task automatic test_lock_loss;
        to(80); bus.pll_locked = 1'b0;
        to(81); bus.pll_locked = 1'b1;
        to(82);
        n_cmp++; if (bus.sys_reset !== 1'b0) begin n_bad++; $display("FAIL ll_sysrst82 got %b exp 0", bus.sys_reset); end
        to(83);
        n_cmp++; if (bus.sys_reset !== 1'b1) begin n_bad++; $display("FAIL ll_sysrst83 got %b exp 1", bus.sys_reset); end
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL ll_rst83 got %b exp 1", bus.pll_rst); end
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL ll_ready83 got %b exp 0", bus.pll_ready); end
        to(86);
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL ll_rst86 got %b exp 1", bus.pll_rst); end
        to(87);
        n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL ll_rst87 got %b exp 0", bus.pll_rst); end
        to(95);
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL ll_ready95 got %b exp 0", bus.pll_ready); end
        to(96);
        n_cmp++; if (bus.pll_ready !== 1'b1) begin n_bad++; $display("FAIL ll_ready96 got %b exp 1", bus.pll_ready); end
        n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL ll_retry got %0d exp 0", bus.retry_count); end
    endtask

    task automatic test_timeout_vs_lock;
        release_reset(1'b0);
        to(101); bus.pll_locked = 1'b1;
        to(104);
        n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL tl_rst104 got %b exp 0", bus.pll_rst); end
        n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL tl_retry104 got %0d exp 0", bus.retry_count); end
        to(111);
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL tl_ready111 got %b exp 0", bus.pll_ready); end
        to(112);
        n_cmp++; if (bus.pll_ready !== 1'b1) begin n_bad++; $display("FAIL tl_ready112 got %b exp 1", bus.pll_ready); end
    endtask

    task automatic test_reset_in_stabilize;
        release_reset(1'b1);
        to(7); reset = 1'b1;
        to(8);
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL rs_pll_rst got %b exp 1", bus.pll_rst); end
        n_cmp++; if (bus.sys_reset !== 1'b1) begin n_bad++; $display("FAIL rs_sys_reset got %b exp 1", bus.sys_reset); end
        reset = 1'b0;
        cyc = 0;
        to(3);
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL rs_rst3 got %b exp 1", bus.pll_rst); end
        to(4);
        n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL rs_rst4 got %b exp 0", bus.pll_rst); end
        to(12);
        n_cmp++; if (bus.pll_ready !== 1'b0) begin n_bad++; $display("FAIL rs_ready12 got %b exp 0", bus.pll_ready); end
        to(13);
        n_cmp++; if (bus.pll_ready !== 1'b1) begin n_bad++; $display("FAIL rs_ready13 got %b exp 1", bus.pll_ready); end
    endtask

    task automatic test_relock_vs_timeout;
        release_reset(1'b0);
        to(207);
        n_cmp++; if (bus.retry_count !== 2'd1) begin n_bad++; $display("FAIL rt_retry207 got %0d exp 1", bus.retry_count); end
        bus.relock_req = 1'b1;
        to(208);
        bus.relock_req = 1'b0;
        n_cmp++; if (bus.retry_count !== 2'd0) begin n_bad++; $display("FAIL rt_retry208 got %0d exp 0", bus.retry_count); end
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL rt_rst208 got %b exp 1", bus.pll_rst); end
        to(212);
        n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL rt_rst212 got %b exp 0", bus.pll_rst); end
        to(312);
        n_cmp++; if (bus.retry_count !== 2'd1) begin n_bad++; $display("FAIL rt_retry312 got %0d exp 1", bus.retry_count); end
        n_cmp++; if (bus.pll_failed !== 1'b0) begin n_bad++; $display("FAIL rt_failed312 got %b exp 0", bus.pll_failed); end
    endtask

    task automatic test_relock_restart;
        release_reset(1'b0);
        to(2); bus.relock_req = 1'b1;
        to(3); bus.relock_req = 1'b0;
        to(6);
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL rr_rst6 got %b exp 1", bus.pll_rst); end
        to(7);
        n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL rr_rst7 got %b exp 0", bus.pll_rst); end
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        test_reset;
        test_power_on;
        test_lock_timeout;
        test_relock_from_fail;
        test_lock_bounce;
        test_lock_loss;
        test_timeout_vs_lock;
        test_reset_in_stabilize;
        test_relock_vs_timeout;
        test_relock_restart;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
